// File: rtl/pool_stream.sv
// pool_stream: buffers one ARRAY_WIDTH^2 frame, then scans each PxP window and emits one pooled value.
// Max pooling by default; define POOL_AVG_EN for truncating average pooling.
module pool_stream #(
    parameter int DATA_WIDTH       = 16,
    parameter int ARRAY_WIDTH      = 3,
    parameter int POOL_FILTER_SIZE = 2,
    parameter int POOL_STRIDE      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);
    localparam int RESULT_WIDTH = ((ARRAY_WIDTH - POOL_FILTER_SIZE) / POOL_STRIDE) + 1;
    localparam int N  = ARRAY_WIDTH * ARRAY_WIDTH;
    localparam int PP = POOL_FILTER_SIZE * POOL_FILTER_SIZE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
`ifdef POOL_AVG_EN
    localparam int ACC_W = DATA_WIDTH + $clog2(PP);
`else
    localparam int ACC_W = DATA_WIDTH;
`endif
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [IW-1:0] WIN_LAST = IW'(POOL_FILTER_SIZE - 1);
    localparam logic [IW-1:0] RES_LAST = IW'(RESULT_WIDTH - 1);
    localparam logic [IW-1:0] STRIDE   = IW'(POOL_STRIDE);
    localparam logic [IW-1:0] SIDE     = IW'(ARRAY_WIDTH);

    typedef enum logic [1:0] {LOAD, SCAN, EMIT} state_t;

    state_t                state;
    logic [IW-1:0]         idx, r, c, i, j;
    logic [ACC_W-1:0]      acc, acc_next;
    logic [DATA_WIDTH-1:0] frame_buf [N];
    logic [DATA_WIDTH-1:0] elem, result;
    logic [IW-1:0]         addr;
    logic                  first;

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) frame_buf[idx] <= in_data;
    end

    always_comb begin
        addr  = (r * STRIDE + i) * SIDE + c * STRIDE + j;
        elem  = frame_buf[addr];
        first = (i == '0) && (j == '0);
`ifdef POOL_AVG_EN
        acc_next = first ? ACC_W'(elem) : acc + ACC_W'(elem);
        result   = DATA_WIDTH'(acc_next / ACC_W'(PP));
`else
        acc_next = (first || elem > acc) ? elem : acc;
        result   = acc_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= LOAD;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            idx       <= '0;
            r         <= '0;
            c         <= '0;
            i         <= '0;
            j         <= '0;
            acc       <= '0;
        end else begin
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        if (idx == IDX_LAST) begin
                            idx      <= '0;
                            r        <= '0;
                            c        <= '0;
                            i        <= '0;
                            j        <= '0;
                            in_ready <= 1'b0;
                            state    <= SCAN;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                SCAN: begin
                    acc <= acc_next;
                    if (j == WIN_LAST) begin
                        j <= '0;
                        if (i == WIN_LAST) begin
                            // last read of the window lands straight in the output register
                            i         <= '0;
                            out_valid <= 1'b1;
                            out_data  <= result;
                            out_last  <= (r == RES_LAST) && (c == RES_LAST);
                            state     <= EMIT;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            r        <= '0;
                            c        <= '0;
                            in_ready <= 1'b1;
                            state    <= LOAD;
                        end else begin
                            if (c == RES_LAST) begin
                                c <= '0;
                                r <= r + 1'b1;
                            end else begin
                                c <= c + 1'b1;
                            end
                            state <= SCAN;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_pool_stream.sv
// Scoreboard bench for pool_stream: 3x3/P2/S1 main instance plus a 4x4/P2/S2 instance.
module tb_pool_stream;
    localparam int DW = 16;
    localparam int AW1 = 3, P1 = 2, S1 = 1, RW1 = (AW1 - P1) / S1 + 1;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, out_last;
    logic [DW-1:0] in_data = '0, out_data;
    logic in_valid2 = 1'b0, out_ready2 = 1'b1;
    logic in_ready2, out_valid2, out_last2;
    logic [DW-1:0] in_data2 = '0, out_data2;

    int n_checks = 0, n_fail = 0;
    logic [DW-1:0] in_q[$];
    logic [DW:0]   exp_q[$];
    logic hs, hs_last, acc_flag;
    logic [DW-1:0] hs_data;

    always #5 clk = ~clk;

    pool_stream dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last));

    pool_stream #(.ARRAY_WIDTH(4), .POOL_FILTER_SIZE(2), .POOL_STRIDE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_last(out_last2));

    function automatic logic [DW-1:0] pool_win(input logic [DW-1:0] f[$], input int aw, p, s, r, c);
        longint unsigned v, e;
        v = 0;
        for (int i = 0; i < p; i++)
            for (int j = 0; j < p; j++) begin
                e = longint'(f[(r * s + i) * aw + c * s + j]);
`ifdef POOL_AVG_EN
                v = v + e;
`else
                if (e > v) v = e;
`endif
            end
`ifdef POOL_AVG_EN
        v = v / longint'(p * p);
`endif
        return v[DW-1:0];
    endfunction

    task automatic load_frame(input logic [DW-1:0] f[$]);
        foreach (f[k]) in_q.push_back(f[k]);
        for (int r = 0; r < RW1; r++)
            for (int c = 0; c < RW1; c++)
                exp_q.push_back({(r == RW1 - 1 && c == RW1 - 1), pool_win(f, AW1, P1, S1, r, c)});
    endtask

    // one clock of the main instance: feed from in_q, record any output handshake
    task automatic step();
        in_valid = (in_q.size() > 0);
        if (in_valid) in_data = in_q[0];
        acc_flag = in_valid && in_ready;
        hs       = out_valid && out_ready;
        hs_data  = out_data;
        hs_last  = out_last;
        @(posedge clk); #1;
        if (acc_flag) void'(in_q.pop_front());
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b exp 0", out_last); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_max_basic();
        logic [DW-1:0] f[$];
        logic [DW:0] e;
        int n, got, cyc;
        f = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        load_frame(f);
        out_ready = 1'b1;
        cyc = 0;
        while (in_q.size() > 0 && cyc < 100) begin step(); cyc++; end
        n = 0;
        while (!out_valid && n < 30) begin step(); n++; end
        n_checks++; if (n != P1 * P1) begin n_fail++; $display("FAIL basic_latency got %0d exp %0d", n, P1 * P1); end
        got = 0; cyc = 0;
        while (got < RW1 * RW1 && cyc < 200) begin
            step(); cyc++;
            if (hs) begin
                got++; n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL basic_extra got %h exp none", hs_data); end
                else begin
                    e = exp_q.pop_front();
                    if ({hs_last, hs_data} !== e) begin n_fail++; $display("FAIL basic_out got %h exp %h", {hs_last, hs_data}, e); end
                end
            end
        end
        n_checks++; if (got != RW1 * RW1) begin n_fail++; $display("FAIL basic_count got %0d exp %0d", got, RW1 * RW1); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after_last got %b exp 1", in_ready); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] f[$];
        logic [DW-1:0] held;
        logic [DW:0] e;
        int got, cyc;
        f = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        load_frame(f);
        out_ready = 1'b0;
        cyc = 0;
        while ((in_q.size() > 0 || !out_valid) && cyc < 200) begin step(); cyc++; end
        held = out_data;
        n_checks++; if ({out_last, held} !== exp_q[0]) begin n_fail++; $display("FAIL bp_first got %h exp %h", {out_last, held}, exp_q[0]); end
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_data = 16'h1234;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
            @(posedge clk); #1;
            in_valid = 1'b0;
            n_checks++; if (out_valid !== 1'b1 || out_data !== held || out_last !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold got v=%b d=%h l=%b exp v=1 d=%h l=0", out_valid, out_data, out_last, held);
            end
        end
        out_ready = 1'b1;
        got = 0; cyc = 0;
        while (got < RW1 * RW1 && cyc < 200) begin
            step(); cyc++;
            if (hs) begin
                got++; n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_extra got %h exp none", hs_data); end
                else begin
                    e = exp_q.pop_front();
                    if ({hs_last, hs_data} !== e) begin n_fail++; $display("FAIL bp_out got %h exp %h", {hs_last, hs_data}, e); end
                end
            end
        end
        n_checks++; if (got != RW1 * RW1) begin n_fail++; $display("FAIL bp_count got %0d exp %0d", got, RW1 * RW1); end
    endtask

    task automatic test_reset_mid_scan();
        logic [DW-1:0] f[$];
        logic [DW:0] e;
        int got, cyc;
        f = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        load_frame(f);
        out_ready = 1'b1;
        cyc = 0; hs = 1'b0;
        while (!hs && cyc < 200) begin step(); cyc++; end
        n_checks++; if (!hs) begin n_fail++; $display("FAIL rst_mid_first got none exp handshake"); end
        step();
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({in_ready, out_valid, out_last} !== 3'b000 || out_data !== '0) begin
            n_fail++; $display("FAIL rst_mid_values got r=%b v=%b l=%b d=%h exp all 0", in_ready, out_valid, out_last, out_data);
        end
        rst_n = 1'b1;
        in_q.delete(); exp_q.delete();
        f = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        load_frame(f);
        got = 0; cyc = 0;
        while (got < RW1 * RW1 && cyc < 300) begin
            step(); cyc++;
            if (hs) begin
                got++; n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL rst_mid_extra got %h exp none", hs_data); end
                else begin
                    e = exp_q.pop_front();
                    if ({hs_last, hs_data} !== e) begin n_fail++; $display("FAIL rst_mid_out got %h exp %h", {hs_last, hs_data}, e); end
                end
            end
        end
        n_checks++; if (got != RW1 * RW1) begin n_fail++; $display("FAIL rst_mid_count got %0d exp %0d", got, RW1 * RW1); end
    endtask

    task automatic test_saturate();
        logic [DW-1:0] f[$];
        logic [DW:0] e;
        int got, cyc;
        for (int k = 0; k < AW1 * AW1; k++) f.push_back(16'hFFFF);
        load_frame(f);
        got = 0; cyc = 0;
        while (got < RW1 * RW1 && cyc < 300) begin
            step(); cyc++;
            if (hs) begin
                got++; n_checks++;
                e = exp_q.size() ? exp_q.pop_front() : '0;
                if ({hs_last, hs_data} !== e || hs_data !== 16'hFFFF) begin
                    n_fail++; $display("FAIL sat_out got %h exp %h", {hs_last, hs_data}, e);
                end
            end
        end
        n_checks++; if (got != RW1 * RW1) begin n_fail++; $display("FAIL sat_count got %0d exp %0d", got, RW1 * RW1); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] fa[$], fb[$];
        logic [DW:0] e;
        int got, lasts, cyc;
        logic overlap;
        for (int k = 0; k < AW1 * AW1; k++) begin
            fa.push_back(DW'($urandom_range(0, 65535)));
            fb.push_back(DW'($urandom_range(0, 65535)));
        end
        load_frame(fa);
        load_frame(fb);
        got = 0; lasts = 0; cyc = 0; overlap = 1'b0;
        while (got < 2 * RW1 * RW1 && cyc < 400) begin
            if (out_valid && in_ready) overlap = 1'b1;
            step(); cyc++;
            if (hs) begin
                got++; n_checks++;
                if (hs_last) lasts++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_extra got %h exp none", hs_data); end
                else begin
                    e = exp_q.pop_front();
                    if ({hs_last, hs_data} !== e) begin n_fail++; $display("FAIL b2b_out got %h exp %h", {hs_last, hs_data}, e); end
                end
                if (hs_last && lasts == 1) begin
                    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_last got %b exp 1", in_ready); end
                end
            end
        end
        n_checks++; if (overlap) begin n_fail++; $display("FAIL b2b_overlap got in_ready=1 during out_valid exp 0"); end
        n_checks++; if (got != 2 * RW1 * RW1 || lasts != 2) begin
            n_fail++; $display("FAIL b2b_count got %0d outs %0d lasts exp %0d outs 2 lasts", got, lasts, 2 * RW1 * RW1);
        end
        n_checks++; if (in_q.size() != 0) begin n_fail++; $display("FAIL b2b_inputs got %0d left exp 0", in_q.size()); end
    endtask

    task automatic test_stride2();
        logic [DW-1:0] f[$];
        logic [DW:0] exp2[$];
        logic [DW:0] e;
        int sent, got, cyc;
        for (int k = 0; k < 16; k++) f.push_back(DW'(k));
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                exp2.push_back({(r == 1 && c == 1), pool_win(f, 4, 2, 2, r, c)});
        sent = 0; got = 0; cyc = 0;
        out_ready2 = 1'b1;
        while (got < 4 && cyc < 300) begin
            in_valid2 = (sent < 16);
            if (sent < 16) in_data2 = f[sent];
            hs = out_valid2 && out_ready2;
            hs_data = out_data2; hs_last = out_last2;
            acc_flag = in_valid2 && in_ready2;
            @(posedge clk); #1;
            cyc++;
            if (acc_flag) sent++;
            if (hs) begin
                got++; n_checks++;
                e = exp2.size() ? exp2.pop_front() : '0;
                if ({hs_last, hs_data} !== e) begin n_fail++; $display("FAIL s2_out got %h exp %h", {hs_last, hs_data}, e); end
            end
        end
        in_valid2 = 1'b0;
        n_checks++; if (got != 4) begin n_fail++; $display("FAIL s2_count got %0d exp 4", got); end
    endtask

    initial begin
        test_reset();
        test_max_basic();
        test_backpressure();
        test_reset_mid_scan();
        test_saturate();
        test_back_to_back();
        test_stride2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
